module_prio: RTL and testbench
==============================

// Module: module_prio
// PURPOSE
// - Output priority selector for the signed-magnitude calculator datapath.
// - Chooses which value the display/output stage shows: operand 1, operand 2 or the multiplier product.
// - Selection follows the ready flags with fixed priority: product > operand 2 > operand 1.
// - Sits between the operand-entry/multiplier blocks and the display driver.
// PARAMETERS
// - W_IN   default 8    magnitude width of operand inputs num_1/num_2
// - W_OUT  default 16   magnitude width of product input and of numero_output (W_OUT >= W_IN)
// PORTS
// - clk            in   1      system clock, all state on rising edge
// - rst            in   1      asynchronous, active-low reset
// - num_1          in   W_IN   operand 1 magnitude
// - sig_1          in   1      operand 1 sign (1 = negative)
// - num_2          in   W_IN   operand 2 magnitude
// - sig_2          in   1      operand 2 sign
// - listo_1        in   1      operand 1 ready (level)
// - listo_2        in   1      operand 2 ready (level)
// - listo          in   1      product ready (level)
// - num_mul        in   W_OUT  product magnitude
// - sig_mul        in   1      product sign
// - numero_output  out  W_OUT  selected magnitude (registered)
// - signo_output   out  1      selected sign (registered)
// BEHAVIOUR
// - Reset (rst=0, async): numero_output=0, signo_output=0, FSM=IDLE. Takes effect immediately, including mid-operation.
// - FSM states: IDLE, SHOW_N1, SHOW_N2, SHOW_MUL. State is evaluated every rising edge:
//   - listo=1 -> SHOW_MUL
//   - else listo_2=1 -> SHOW_N2
//   - else listo_1=1 -> SHOW_N1
//   - else no flag -> see CONFIGURATION
// - Simultaneous flags: highest priority wins; lower flags are ignored that cycle.
// - Output register loads the selected source on the same edge the state is chosen; latency = 1 clock.
// - Output tracks the live inputs of the selected source every cycle, so a changing num_* or sig_* while its flag stays high propagates after 1 clock.
// - Width rule: num_1/num_2 are zero-extended to W_OUT; num_mul passes through unchanged.
// - Sign normalisation: if the selected magnitude is 0, signo_output=0 (no negative zero).
// - X/undefined ready flags are not tolerated; drivers hold flags at 0 when inactive.
// CONFIGURATION
// - Macro PRIO_HOLD_EN:
//   - Defined: with no flag asserted, the FSM keeps its state and the outputs keep their last loaded values.
//   - Undefined (default): with no flag asserted, the FSM returns to IDLE and the outputs clear to 0 / sign 0 on the next edge.
// TESTING
// 1. Reset: rst=0 with arbitrary inputs -> numero_output=0 and signo_output=0 immediately; stay there while rst=0.
// 2. Operand 1: num_1=15, sig_1=0, listo_1=1 -> next edge: 15, sign 0, state SHOW_N1.
// 3. Operand 2 priority: additionally num_2=10, sig_2=1, listo_2=1 -> next edge: 10, sign 1.
// 4. Product priority: additionally num_mul=150, sig_mul=1, listo=1 -> next edge: 150, sign 1; holds while all flags stay high.
// 5. Negative zero: listo_1=1, num_1=0, sig_1=1 -> output 0, sign 0.
// 6. Flags drop to 0 -> outputs hold 150/1 with PRIO_HOLD_EN, or clear to 0/0 without it; then assert rst mid-run -> immediate 0/0.

Source files
------------

// File: rtl/module_prio.sv
// rtl/module_prio.sv - fixed-priority output selector (product > operand 2 > operand 1); optional macro PRIO_HOLD_EN
module module_prio #(
  parameter int W_IN  = 8,
  parameter int W_OUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_IN-1:0]  num_1,
  input  logic             sig_1,
  input  logic [W_IN-1:0]  num_2,
  input  logic             sig_2,
  input  logic             listo_1,
  input  logic             listo_2,
  input  logic             listo,
  input  logic [W_OUT-1:0] num_mul,
  input  logic             sig_mul,
  output logic [W_OUT-1:0] numero_output,
  output logic             signo_output
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHOW_N1  = 2'd1,
    SHOW_N2  = 2'd2,
    SHOW_MUL = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [W_OUT-1:0]   numero_q, numero_d;
  logic               signo_q, signo_d;
  logic [W_OUT-1:0]   sel_mag;
  logic               sel_sig;

  // Next state from the ready flags, highest priority first.
  always_comb begin
    state_d = state_q;
    if (listo) begin
      state_d = SHOW_MUL;
    end else if (listo_2) begin
      state_d = SHOW_N2;
    end else if (listo_1) begin
      state_d = SHOW_N1;
    end else begin
`ifdef PRIO_HOLD_EN
      state_d = state_q;
`else
      state_d = IDLE;
`endif
    end
  end

  // Source mux: the live inputs of the chosen source; no flag means hold or clear.
  always_comb begin
    sel_mag = '0;
    sel_sig = 1'b0;
    if (listo) begin
      sel_mag = num_mul;
      sel_sig = sig_mul;
    end else if (listo_2) begin
      sel_mag = W_OUT'(num_2);
      sel_sig = sig_2;
    end else if (listo_1) begin
      sel_mag = W_OUT'(num_1);
      sel_sig = sig_1;
    end else begin
`ifdef PRIO_HOLD_EN
      sel_mag = numero_q;
      sel_sig = signo_q;
`else
      sel_mag = '0;
      sel_sig = 1'b0;
`endif
    end
  end

  // A zero magnitude is always shown as positive.
  always_comb begin
    numero_d = sel_mag;
    signo_d  = sel_sig & (|sel_mag);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      numero_q <= '0;
      signo_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      numero_q <= numero_d;
      signo_q  <= signo_d;
    end
  end

  assign numero_output = numero_q;
  assign signo_output  = signo_q;

endmodule

// File: tb/tb_module_prio.sv
// tb/tb_module_prio.sv - scoreboard bench for module_prio with random stimulus
module tb_module_prio;
  localparam int W_IN  = 8;
  localparam int W_OUT = 16;

  logic             clk;
  logic             rst;
  logic [W_IN-1:0]  num_1, num_2;
  logic             sig_1, sig_2;
  logic             listo_1, listo_2, listo;
  logic [W_OUT-1:0] num_mul;
  logic             sig_mul;
  logic [W_OUT-1:0] numero_output;
  logic             signo_output;

  module_prio #(.W_IN(W_IN), .W_OUT(W_OUT)) dut (
    .clk(clk), .rst(rst),
    .num_1(num_1), .sig_1(sig_1), .num_2(num_2), .sig_2(sig_2),
    .listo_1(listo_1), .listo_2(listo_2), .listo(listo),
    .num_mul(num_mul), .sig_mul(sig_mul),
    .numero_output(numero_output), .signo_output(signo_output)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [W_OUT-1:0] mag;
    logic             sgn;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_shown;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [W_OUT:0] act, input logic [W_OUT:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got mag=%0d sign=%0d, want mag=%0d sign=%0d",
               name, act[W_OUT:1], act[0], req[W_OUT:1], req[0]);
    end
  endtask

  // Reference: the value the display should show after the next edge.
  function automatic exp_t predict();
    exp_t e;
    int   m;
    int   s;
    if (listo === 1'b1) begin
      m = int'(num_mul); s = int'(sig_mul);
    end else if (listo_2 === 1'b1) begin
      m = int'(num_2); s = int'(sig_2);
    end else if (listo_1 === 1'b1) begin
      m = int'(num_1); s = int'(sig_1);
    end else begin
`ifdef PRIO_HOLD_EN
      m = int'(last_shown.mag); s = int'(last_shown.sgn);
`else
      m = 0; s = 0;
`endif
    end
    if (m == 0) s = 0;
    e.mag = W_OUT'(m);
    e.sgn = (s != 0);
    return e;
  endfunction

  task automatic issue(input logic [W_IN-1:0] n1, input logic s1, input logic f1,
                       input logic [W_IN-1:0] n2, input logic s2, input logic f2,
                       input logic [W_OUT-1:0] nm, input logic sm, input logic fm);
    exp_t e;
    @(negedge clk);
    num_1 = n1; sig_1 = s1; listo_1 = f1;
    num_2 = n2; sig_2 = s2; listo_2 = f2;
    num_mul = nm; sig_mul = sm; listo = fm;
    e = predict();
    last_shown = e;
    exp_q.push_back(e);
  endtask

  // Monitor: the registered output is presented every edge; compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", {numero_output, signo_output}, {e.mag, e.sgn});
      end
    end
  end

  function automatic logic [W_IN-1:0] rnd_in();
    return ($urandom_range(0, 3) == 0) ? '0 : W_IN'($urandom);
  endfunction

  function automatic logic [W_OUT-1:0] rnd_mul();
    return ($urandom_range(0, 3) == 0) ? '0 : W_OUT'($urandom);
  endfunction

  initial begin
    rst = 1'b1;
    num_1 = 8'd33; sig_1 = 1'b1; listo_1 = 1'b1;
    num_2 = 8'd44; sig_2 = 1'b1; listo_2 = 1'b1;
    num_mul = 16'd999; sig_mul = 1'b1; listo = 1'b1;
    last_shown = '0;

    // Asynchronous reset with flags active: clears immediately and stays cleared.
    #3 rst = 1'b0;
    #1 check("reset_immediate", {numero_output, signo_output}, 17'd0);
    repeat (3) begin
      @(posedge clk);
      #1 check("reset_hold", {numero_output, signo_output}, 17'd0);
    end
    @(negedge clk);
    listo_1 = 1'b0; listo_2 = 1'b0; listo = 1'b0;
    rst = 1'b1;

    // Directed sequence.
    issue(8'd15, 1'b0, 1'b1, 8'd0,  1'b0, 1'b0, 16'd0,   1'b0, 1'b0);
    issue(8'd15, 1'b0, 1'b1, 8'd10, 1'b1, 1'b1, 16'd0,   1'b0, 1'b0);
    issue(8'd15, 1'b0, 1'b1, 8'd10, 1'b1, 1'b1, 16'd150, 1'b1, 1'b1);
    issue(8'd15, 1'b0, 1'b1, 8'd10, 1'b1, 1'b1, 16'd150, 1'b1, 1'b1);
    issue(8'd15, 1'b0, 1'b1, 8'd10, 1'b1, 1'b1, 16'd150, 1'b1, 1'b1);
    issue(8'd0,  1'b1, 1'b1, 8'd0,  1'b0, 1'b0, 16'd0,   1'b0, 1'b0);
    issue(8'd255,1'b1, 1'b1, 8'd0,  1'b0, 1'b0, 16'd0,   1'b0, 1'b0);
    issue(8'd0,  1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 16'd0,   1'b1, 1'b1);
    issue(8'd0,  1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 16'hFFFF,1'b1, 1'b1);
    issue(8'd0,  1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 16'd150, 1'b1, 1'b1);
    issue(8'd0,  1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 16'd0,   1'b0, 1'b0);
    issue(8'd0,  1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 16'd0,   1'b0, 1'b0);

    // Random traffic, flags often low so both idle behaviours are exercised.
    for (int i = 0; i < 400; i++) begin
      issue(rnd_in(), 1'($urandom), 1'($urandom_range(0, 2) == 0),
            rnd_in(), 1'($urandom), 1'($urandom_range(0, 2) == 0),
            rnd_mul(), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    // Mid-run reset between edges while a product is shown.
    issue(8'd1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 16'd777, 1'b1, 1'b1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("midrun_reset", {numero_output, signo_output}, 17'd0);
    @(posedge clk);
    #1 check("midrun_reset_hold", {numero_output, signo_output}, 17'd0);
    @(negedge clk);
    rst = 1'b1;
    last_shown = '0;
    issue(8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    issue(8'd7, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    issue(8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
